buspirate_top: RTL and testbench

//  FPGA top of the Bus Pirate IO core. Exposes a 16-bit async parallel register bus to the host MCU.

---
 rtl/buspirate_top_if.sv | 19 +
 rtl/buspirate_top.sv | 230 +++++++++++++++++++++++
 tb/tb_buspirate_top.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/buspirate_top_if.sv
// -----------------------------------------------------------------------------
// buspirate_top_if
//   Host MCU parallel-bus control group: the three active-low asynchronous
//   strobes and the word address. The bidirectional data bus stays a plain
//   inout port on buspirate_top so it can be resolved as a tristate net.
//   master : host side (drives strobes and address)
//   slave  : FPGA core side (samples strobes and address)
// -----------------------------------------------------------------------------
interface buspirate_top_if #(
    parameter int ADD_WIDTH = 6
);
    logic                 mc_oe;
    logic                 mc_ce;
    logic                 mc_we;
    logic [ADD_WIDTH-1:0] mc_add;

    modport master (output mc_oe, output mc_ce, output mc_we, output mc_add);
    modport slave  (input  mc_oe, input  mc_ce, input  mc_we, input  mc_add);
endinterface

// File: rtl/buspirate_top.sv
// -----------------------------------------------------------------------------
// buspirate_top
//   Bus Pirate IO core. A 16-bit asynchronous host register bus controls five
//   buffered IO pins, an 8-bit output latch, two edge interrupt lines and
//   bit-banged quad-SPI SRAM pins.
// Ports
//   clock, reset            system clock (posedge), synchronous active-low reset
//   bufdir_/bufod_/bufio_*  per-pin buffer direction, open-drain flag, data
//   lat_oe, lat             latch enable (active-low) and data
//   mc (slave modport)      host strobes mc_oe/mc_ce/mc_we and address mc_add
//   mc_data                 host data, driven only during a host read
//   irq0, irq1              rise / fall event interrupts
//   sram_clock, sram*_cs    SRAM clock and active-low chip selects
//   sram0_sio, sram1_sio    SRAM quad data lines
// -----------------------------------------------------------------------------
module buspirate_top #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     bufdir_mosi,
    output logic                     bufdir_clock,
    output logic                     bufdir_miso,
    output logic                     bufdir_cs,
    output logic                     bufdir_aux,
    output logic                     bufod_mosi,
    output logic                     bufod_clock,
    output logic                     bufod_miso,
    output logic                     bufod_cs,
    output logic                     bufod_aux,
    inout  wire                      bufio_mosi,
    inout  wire                      bufio_clock,
    inout  wire                      bufio_miso,
    inout  wire                      bufio_cs,
    inout  wire                      bufio_aux,
    output logic                     lat_oe,
    output logic [7:0]               lat,
    buspirate_top_if.slave           mc,
    inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
    output logic                     irq0,
    output logic                     irq1,
    output logic                     sram_clock,
    output logic                     sram0_cs,
    output logic                     sram1_cs,
    inout  wire  [3:0]               sram0_sio,
    inout  wire  [3:0]               sram1_sio
);

    // Every asynchronous input shares one synchroniser vector:
    // [0] write strobe, [5:1] pins (aux..mosi), [13:6] {sram1_sio, sram0_sio}
    localparam int SW = 14;

    logic [SW-1:0]            sync_q [SYNC_STAGES];
    logic [SW-1:0]            sync_d [SYNC_STAGES];
    logic [SW-1:0]            sync_raw;
    logic                     wr_last_q, wr_last_d;
    logic [4:0]               pin_prev_q, pin_prev_d;
    logic [MC_ADD_WIDTH-1:0]  add_cap_q, add_cap_d;
    logic [MC_DATA_WIDTH-1:0] data_cap_q, data_cap_d;
    logic [4:0]               pin_dir_q, pin_dir_d;
    logic [4:0]               pin_od_q, pin_od_d;
    logic [4:0]               pin_out_q, pin_out_d;
    logic [8:0]               latch_q, latch_d;
    logic [15:0]              irq_en_q, irq_en_d;
    logic [15:0]              irq_stat_q, irq_stat_d;
    logic [9:0]               sram_ctrl_q, sram_ctrl_d;
    logic                     irq0_q, irq0_d;
    logic                     irq1_q, irq1_d;

    logic                     wr_s;
    logic [4:0]               pin_s;
    logic [7:0]               sram_s;
    logic                     commit;
    logic [15:0]              w1c;
    logic [4:0]               rise;
    logic [4:0]               fall;
    logic [4:0]               drive_en;
    logic [15:0]              reg_rd;
    logic                     rd_en;
    logic                     unused_bits;

    assign sync_raw = {sram1_sio, sram0_sio,
                       bufio_aux, bufio_cs, bufio_miso, bufio_clock, bufio_mosi,
                       ~mc.mc_ce & ~mc.mc_we};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            wr_last_q   <= 1'b0;
            pin_prev_q  <= '0;
            add_cap_q   <= '0;
            data_cap_q  <= '0;
            pin_dir_q   <= '0;
            pin_od_q    <= '0;
            pin_out_q   <= '0;
            latch_q     <= '0;
            irq_en_q    <= '0;
            irq_stat_q  <= '0;
            sram_ctrl_q <= 10'h006;
            irq0_q      <= 1'b0;
            irq1_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            wr_last_q   <= wr_last_d;
            pin_prev_q  <= pin_prev_d;
            add_cap_q   <= add_cap_d;
            data_cap_q  <= data_cap_d;
            pin_dir_q   <= pin_dir_d;
            pin_od_q    <= pin_od_d;
            pin_out_q   <= pin_out_d;
            latch_q     <= latch_d;
            irq_en_q    <= irq_en_d;
            irq_stat_q  <= irq_stat_d;
            sram_ctrl_q <= sram_ctrl_d;
            irq0_q      <= irq0_d;
            irq1_q      <= irq1_d;
        end
    end

    // ------------------------------------------------- synchronise + write
    always_comb begin
        sync_d[0] = sync_raw;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

        wr_s   = sync_q[SYNC_STAGES-1][0];
        pin_s  = sync_q[SYNC_STAGES-1][5:1];
        sram_s = sync_q[SYNC_STAGES-1][13:6];

        wr_last_d  = wr_s;
        pin_prev_d = pin_s;

        // Bus is sampled for as long as the synchronised strobe is high, so
        // the commit uses values that were stable at the end of the strobe.
        add_cap_d  = wr_s ? mc.mc_add : add_cap_q;
        data_cap_d = wr_s ? mc_data   : data_cap_q;

        // Falling edge of the synchronised strobe: exactly one commit.
        commit = wr_last_q & ~wr_s;

        pin_dir_d   = pin_dir_q;
        pin_od_d    = pin_od_q;
        pin_out_d   = pin_out_q;
        latch_d     = latch_q;
        irq_en_d    = irq_en_q;
        sram_ctrl_d = sram_ctrl_q;
        w1c         = '0;

        if (commit) begin
            case (add_cap_q)
                MC_ADD_WIDTH'(1): pin_dir_d   = data_cap_q[4:0];
                MC_ADD_WIDTH'(2): pin_od_d    = data_cap_q[4:0];
                MC_ADD_WIDTH'(3): pin_out_d   = data_cap_q[4:0];
                MC_ADD_WIDTH'(5): latch_d     = data_cap_q[8:0];
                MC_ADD_WIDTH'(6): irq_en_d    = data_cap_q[15:0] & 16'h1F1F;
                MC_ADD_WIDTH'(7): w1c         = data_cap_q[15:0] & 16'h1F1F;
                MC_ADD_WIDTH'(8): sram_ctrl_d = data_cap_q[9:0] & 10'h3F7;
                default: ;
            endcase
        end

        // Event set wins over a write-1-clear landing in the same cycle.
        rise       = pin_s & ~pin_prev_q;
        fall       = ~pin_s & pin_prev_q;
        irq_stat_d = (irq_stat_q & ~w1c) | {3'b000, fall, 3'b000, rise};

        irq0_d = |(irq_stat_q[4:0]  & irq_en_q[4:0]);
        irq1_d = |(irq_stat_q[12:8] & irq_en_q[12:8]);
    end

    assign unused_bits = ^data_cap_q[MC_DATA_WIDTH-1:13];

    // ------------------------------------------------------------- read mux
    always_comb begin
        reg_rd = '0;
        case (mc.mc_add)
            MC_ADD_WIDTH'(0): reg_rd = 16'h4250;
            MC_ADD_WIDTH'(1): reg_rd = {11'd0, pin_dir_q};
            MC_ADD_WIDTH'(2): reg_rd = {11'd0, pin_od_q};
            MC_ADD_WIDTH'(3): reg_rd = {11'd0, pin_out_q};
            MC_ADD_WIDTH'(4): reg_rd = {11'd0, pin_s};
            MC_ADD_WIDTH'(5): reg_rd = {7'd0, latch_q};
            MC_ADD_WIDTH'(6): reg_rd = irq_en_q;
            MC_ADD_WIDTH'(7): reg_rd = irq_stat_q;
            MC_ADD_WIDTH'(8): reg_rd = {6'd0, sram_ctrl_q};
            MC_ADD_WIDTH'(9): reg_rd = {8'd0, sram_s};
            default:          reg_rd = '0;
        endcase
    end

    // Combinational read path; the bus is released while in reset.
    assign rd_en   = reset & ~mc.mc_ce & ~mc.mc_oe & mc.mc_we;
    assign mc_data = rd_en ? MC_DATA_WIDTH'(reg_rd) : {MC_DATA_WIDTH{1'bz}};

    // ----------------------------------------------------------- pin drive
    // Open-drain with OUT=1 releases the pin instead of driving high.
    assign drive_en = pin_dir_q & ~(pin_od_q & pin_out_q);

    assign bufdir_mosi  = drive_en[0];
    assign bufdir_clock = drive_en[1];
    assign bufdir_miso  = drive_en[2];
    assign bufdir_cs    = drive_en[3];
    assign bufdir_aux   = drive_en[4];

    assign bufod_mosi   = pin_od_q[0];
    assign bufod_clock  = pin_od_q[1];
    assign bufod_miso   = pin_od_q[2];
    assign bufod_cs     = pin_od_q[3];
    assign bufod_aux    = pin_od_q[4];

    assign bufio_mosi   = drive_en[0] ? pin_out_q[0] : 1'bz;
    assign bufio_clock  = drive_en[1] ? pin_out_q[1] : 1'bz;
    assign bufio_miso   = drive_en[2] ? pin_out_q[2] : 1'bz;
    assign bufio_cs     = drive_en[3] ? pin_out_q[3] : 1'bz;
    assign bufio_aux    = drive_en[4] ? pin_out_q[4] : 1'bz;

    assign lat    = latch_q[7:0];
    assign lat_oe = ~latch_q[8];
    assign irq0   = irq0_q;
    assign irq1   = irq1_q;

    assign sram_clock = sram_ctrl_q[0];
    assign sram0_cs   = sram_ctrl_q[1];
    assign sram1_cs   = sram_ctrl_q[2];
    assign sram0_sio  = sram_ctrl_q[8] ? sram_ctrl_q[7:4] : 4'bzzzz;
    assign sram1_sio  = sram_ctrl_q[9] ? sram_ctrl_q[7:4] : 4'bzzzz;

endmodule

// File: tb/tb_buspirate_top.sv
// -----------------------------------------------------------------------------
// tb_buspirate_top
//   Directed bench for buspirate_top. The bench models the outside world of
//   each tristate net: the host drives mc_data only while writing (or with a
//   known background value when the core must be released), the pin buffers
//   drive tb_pin_val whenever the core leaves a pin as input, and the SRAMs
//   drive their sio lines when enabled. A released net therefore reads back
//   the bench's own value, and any illegal drive from the core disturbs it.
// -----------------------------------------------------------------------------
module tb_buspirate_top;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_data;
    logic        tb_data_en;
    logic [4:0]  tb_pin_val;
    logic [3:0]  tb_sram0_val, tb_sram1_val;
    logic        tb_sram0_en, tb_sram1_en;

    wire  [15:0] mc_data;
    wire         bufio_mosi, bufio_clock, bufio_miso, bufio_cs, bufio_aux;
    wire  [3:0]  sram0_sio, sram1_sio;
    logic        bufdir_mosi, bufdir_clock, bufdir_miso, bufdir_cs, bufdir_aux;
    logic        bufod_mosi, bufod_clock, bufod_miso, bufod_cs, bufod_aux;
    logic        lat_oe, irq0, irq1, sram_clock, sram0_cs, sram1_cs;
    logic [7:0]  lat;

    int tests_run = 0;
    int tests_failed = 0;

    buspirate_top_if mc_bus ();

    buspirate_top dut (
        .clock(clk), .reset(rst_n),
        .bufdir_mosi(bufdir_mosi), .bufdir_clock(bufdir_clock), .bufdir_miso(bufdir_miso),
        .bufdir_cs(bufdir_cs), .bufdir_aux(bufdir_aux),
        .bufod_mosi(bufod_mosi), .bufod_clock(bufod_clock), .bufod_miso(bufod_miso),
        .bufod_cs(bufod_cs), .bufod_aux(bufod_aux),
        .bufio_mosi(bufio_mosi), .bufio_clock(bufio_clock), .bufio_miso(bufio_miso),
        .bufio_cs(bufio_cs), .bufio_aux(bufio_aux),
        .lat_oe(lat_oe), .lat(lat), .mc(mc_bus.slave), .mc_data(mc_data),
        .irq0(irq0), .irq1(irq1), .sram_clock(sram_clock),
        .sram0_cs(sram0_cs), .sram1_cs(sram1_cs),
        .sram0_sio(sram0_sio), .sram1_sio(sram1_sio)
    );

    assign mc_data     = tb_data_en ? tb_data : 16'hzzzz;
    assign bufio_mosi  = bufdir_mosi  ? 1'bz : tb_pin_val[0];
    assign bufio_clock = bufdir_clock ? 1'bz : tb_pin_val[1];
    assign bufio_miso  = bufdir_miso  ? 1'bz : tb_pin_val[2];
    assign bufio_cs    = bufdir_cs    ? 1'bz : tb_pin_val[3];
    assign bufio_aux   = bufdir_aux   ? 1'bz : tb_pin_val[4];
    assign sram0_sio   = tb_sram0_en ? tb_sram0_val : 4'bzzzz;
    assign sram1_sio   = tb_sram1_en ? tb_sram1_val : 4'bzzzz;

    wire [4:0] dir_v = {bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi};
    wire [4:0] od_v  = {bufod_aux, bufod_cs, bufod_miso, bufod_clock, bufod_mosi};
    wire [4:0] io_v  = {bufio_aux, bufio_cs, bufio_miso, bufio_clock, bufio_mosi};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        mc_bus.mc_add = a;
        tb_data = d;
        tb_data_en = 1'b1;
        mc_bus.mc_ce = 1'b0;
        mc_bus.mc_we = 1'b0;
        repeat (4) @(negedge clk);
        mc_bus.mc_we = 1'b1;
        mc_bus.mc_ce = 1'b1;
        repeat (4) @(negedge clk);
        tb_data_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic host_read(input logic [5:0] a, output logic [15:0] d);
        @(negedge clk);
        mc_bus.mc_add = a;
        mc_bus.mc_we = 1'b1;
        mc_bus.mc_ce = 1'b0;
        mc_bus.mc_oe = 1'b0;
        #2;
        d = mc_data;
        mc_bus.mc_oe = 1'b1;
        mc_bus.mc_ce = 1'b1;
    endtask

    task automatic test_reset();
        tb_sram0_en = 1'b1; tb_sram0_val = 4'h3;
        tb_sram1_en = 1'b1; tb_sram1_val = 4'h5;
        rst_n = 1'b0;
        // Host attempts a read during reset; background 0 on the bus must survive.
        tb_data = 16'h0000; tb_data_en = 1'b1;
        mc_bus.mc_add = 6'h00; mc_bus.mc_we = 1'b1; mc_bus.mc_ce = 1'b0; mc_bus.mc_oe = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        tests_run++; if (mc_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_mc_data: got %h expected 0000", mc_data); end
        tests_run++; if (dir_v !== 5'h00) begin tests_failed++; $display("FAIL reset_bufdir: got %h expected 00", dir_v); end
        tests_run++; if (od_v !== 5'h00) begin tests_failed++; $display("FAIL reset_bufod: got %h expected 00", od_v); end
        tests_run++; if ({lat_oe, lat} !== 9'h100) begin tests_failed++; $display("FAIL reset_latch: got %h expected 100", {lat_oe, lat}); end
        tests_run++; if ({irq1, irq0} !== 2'b00) begin tests_failed++; $display("FAIL reset_irq: got %b expected 00", {irq1, irq0}); end
        tests_run++; if ({sram1_cs, sram0_cs, sram_clock} !== 3'b110) begin tests_failed++; $display("FAIL reset_sram_ctl: got %b expected 110", {sram1_cs, sram0_cs, sram_clock}); end
        tests_run++; if ({sram1_sio, sram0_sio} !== 8'h53) begin tests_failed++; $display("FAIL reset_sram_sio: got %h expected 53", {sram1_sio, sram0_sio}); end
        mc_bus.mc_ce = 1'b1; mc_bus.mc_oe = 1'b1; tb_data_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_id_read();
        logic [15:0] d;
        host_read(6'h00, d);
        tests_run++; if (d !== 16'h4250) begin tests_failed++; $display("FAIL id_read: got %h expected 4250", d); end
        host_read(6'h08, d);
        tests_run++; if (d !== 16'h0006) begin tests_failed++; $display("FAIL sram_ctrl_reset: got %h expected 0006", d); end
        // mc_oe high: core must not drive, background 0000 must be seen.
        @(negedge clk);
        tb_data = 16'h0000; tb_data_en = 1'b1;
        mc_bus.mc_add = 6'h00; mc_bus.mc_ce = 1'b0; mc_bus.mc_we = 1'b1; mc_bus.mc_oe = 1'b1;
        #2;
        tests_run++; if (mc_data !== 16'h0000) begin tests_failed++; $display("FAIL oe_high_release: got %h expected 0000", mc_data); end
        mc_bus.mc_ce = 1'b1; tb_data_en = 1'b0;
        $display("[TB] id read: %h", d);
    endtask

    task automatic test_pins();
        logic [15:0] d;
        host_write(6'h01, 16'h001F);
        host_write(6'h03, 16'h0015);
        #1;
        tests_run++; if (dir_v !== 5'h1F) begin tests_failed++; $display("FAIL pins_bufdir: got %h expected 1f", dir_v); end
        tests_run++; if (io_v !== 5'h15) begin tests_failed++; $display("FAIL pins_bufio: got %h expected 15", io_v); end
        host_read(6'h01, d);
        tests_run++; if (d !== 16'h001F) begin tests_failed++; $display("FAIL pin_dir_rb: got %h expected 001f", d); end
        host_read(6'h03, d);
        tests_run++; if (d !== 16'h0015) begin tests_failed++; $display("FAIL pin_out_rb: got %h expected 0015", d); end
        host_read(6'h04, d);
        tests_run++; if (d !== 16'h0015) begin tests_failed++; $display("FAIL pin_in_rb: got %h expected 0015", d); end
        $display("[TB] pins: dir=%h io=%h", dir_v, io_v);
    endtask

    task automatic test_open_drain();
        logic [15:0] d;
        host_write(6'h02, 16'h0010);
        #1;
        tests_run++; if (dir_v !== 5'h0F) begin tests_failed++; $display("FAIL od_release_dir: got %h expected 0f", dir_v); end
        tests_run++; if (od_v !== 5'h10) begin tests_failed++; $display("FAIL od_flag: got %h expected 10", od_v); end
        tests_run++; if (io_v !== 5'h05) begin tests_failed++; $display("FAIL od_release_io: got %h expected 05", io_v); end
        host_write(6'h03, 16'h0005);
        #1;
        tests_run++; if (dir_v !== 5'h1F) begin tests_failed++; $display("FAIL od_drive_low_dir: got %h expected 1f", dir_v); end
        tests_run++; if (io_v !== 5'h05) begin tests_failed++; $display("FAIL od_drive_low_io: got %h expected 05", io_v); end
        host_read(6'h02, d);
        tests_run++; if (d !== 16'h0010) begin tests_failed++; $display("FAIL pin_od_rb: got %h expected 0010", d); end
        $display("[TB] open drain: dir=%h io=%h", dir_v, io_v);
    endtask

    task automatic test_irq();
        logic [15:0] d;
        host_write(6'h01, 16'h0000);
        host_write(6'h07, 16'h1F1F);
        host_read(6'h07, d);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL irq_stat_clear_all: got %h expected 0000", d); end
        host_write(6'h06, 16'h1010);
        host_read(6'h06, d);
        tests_run++; if (d !== 16'h1010) begin tests_failed++; $display("FAIL irq_en_rb: got %h expected 1010", d); end
        tests_run++; if ({irq1, irq0} !== 2'b00) begin tests_failed++; $display("FAIL irq_idle: got %b expected 00", {irq1, irq0}); end
        @(negedge clk); tb_pin_val[4] = 1'b1;
        repeat (8) @(negedge clk); #1;
        tests_run++; if ({irq1, irq0} !== 2'b01) begin tests_failed++; $display("FAIL irq_rise: got %b expected 01", {irq1, irq0}); end
        @(negedge clk); tb_pin_val[4] = 1'b0;
        repeat (8) @(negedge clk); #1;
        tests_run++; if ({irq1, irq0} !== 2'b11) begin tests_failed++; $display("FAIL irq_fall: got %b expected 11", {irq1, irq0}); end
        host_read(6'h07, d);
        tests_run++; if (d !== 16'h1010) begin tests_failed++; $display("FAIL irq_stat_rb: got %h expected 1010", d); end
        host_write(6'h07, 16'h1010);
        #1;
        tests_run++; if ({irq1, irq0} !== 2'b00) begin tests_failed++; $display("FAIL irq_w1c: got %b expected 00", {irq1, irq0}); end
        // Status bits set even when the source is not enabled, without an IRQ.
        @(negedge clk); tb_pin_val[0] = 1'b1;
        repeat (8) @(negedge clk); #1;
        tests_run++; if (irq0 !== 1'b0) begin tests_failed++; $display("FAIL irq_masked: got %b expected 0", irq0); end
        host_read(6'h07, d);
        tests_run++; if (d !== 16'h0001) begin tests_failed++; $display("FAIL irq_stat_masked: got %h expected 0001", d); end
        $display("[TB] irq: stat=%h", d);
    endtask

    task automatic test_latch();
        logic [15:0] d;
        host_write(6'h05, 16'h01A5);
        #1;
        tests_run++; if ({lat_oe, lat} !== 9'h0A5) begin tests_failed++; $display("FAIL latch_enable: got %h expected 0a5", {lat_oe, lat}); end
        host_read(6'h05, d);
        tests_run++; if (d !== 16'h01A5) begin tests_failed++; $display("FAIL latch_rb: got %h expected 01a5", d); end
        host_write(6'h05, 16'h00A5);
        #1;
        tests_run++; if ({lat_oe, lat} !== 9'h1A5) begin tests_failed++; $display("FAIL latch_disable: got %h expected 1a5", {lat_oe, lat}); end
        $display("[TB] latch: lat=%h lat_oe=%b", lat, lat_oe);
    endtask

    task automatic test_sram();
        logic [15:0] d;
        tb_sram0_en = 1'b0;
        tb_sram1_en = 1'b1; tb_sram1_val = 4'h5;
        host_write(6'h08, 16'h01A1);
        #1;
        tests_run++; if ({sram1_cs, sram0_cs, sram_clock} !== 3'b001) begin tests_failed++; $display("FAIL sram_ctl_pins: got %b expected 001", {sram1_cs, sram0_cs, sram_clock}); end
        tests_run++; if (sram0_sio !== 4'hA) begin tests_failed++; $display("FAIL sram0_drive: got %h expected a", sram0_sio); end
        tests_run++; if (sram1_sio !== 4'h5) begin tests_failed++; $display("FAIL sram1_release: got %h expected 5", sram1_sio); end
        host_read(6'h09, d);
        tests_run++; if (d !== 16'h005A) begin tests_failed++; $display("FAIL sram_in_rb: got %h expected 005a", d); end
        $display("[TB] sram: in=%h", d);
    endtask

    task automatic test_unmapped();
        logic [15:0] d;
        host_write(6'h20, 16'hFFFF);
        host_read(6'h20, d);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL unmapped_read: got %h expected 0000", d); end
        host_read(6'h05, d);
        tests_run++; if (d !== 16'h00A5) begin tests_failed++; $display("FAIL unmapped_write_ignored: got %h expected 00a5", d); end
        $display("[TB] unmapped: %h", d);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        mc_bus.mc_add = 6'h05; tb_data = 16'h01FF; tb_data_en = 1'b1;
        mc_bus.mc_ce = 1'b0; mc_bus.mc_we = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        mc_bus.mc_we = 1'b1; mc_bus.mc_ce = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tb_data_en = 1'b0;
        repeat (4) @(negedge clk); #1;
        tests_run++; if ({lat_oe, lat} !== 9'h100) begin tests_failed++; $display("FAIL reset_abort_no_commit: got %h expected 100", {lat_oe, lat}); end
        $display("[TB] reset abort: lat=%h lat_oe=%b", lat, lat_oe);
    endtask

    initial begin
        rst_n = 1'b0;
        tb_data = 16'h0000; tb_data_en = 1'b0;
        tb_pin_val = 5'h00;
        tb_sram0_val = 4'h0; tb_sram1_val = 4'h0;
        tb_sram0_en = 1'b0; tb_sram1_en = 1'b0;
        mc_bus.mc_oe = 1'b1; mc_bus.mc_ce = 1'b1; mc_bus.mc_we = 1'b1; mc_bus.mc_add = '0;
        test_reset();
        test_id_read();
        test_pins();
        test_open_drain();
        test_irq();
        test_latch();
        test_sram();
        test_unmapped();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
